// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port of the fetch unit.
// Handshake: a request is accepted in a cycle where memRd=1 and memStall=0.
// memDone marks memData valid for the oldest accepted request; at most one is outstanding.
interface fetch_ctrl_if;
  logic [15:0] memAddr;
  logic        memRd;
  logic        memStall;
  logic        memDone;
  logic [15:0] memData;

  modport master (
    output memAddr,
    output memRd,
    input  memStall,
    input  memDone,
    input  memData
  );

  modport slave (
    input  memAddr,
    input  memRd,
    output memStall,
    output memDone,
    output memData
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one outstanding memory read,
// a one-entry skid for decode back-pressure, redirect/halt handling, sticky protocol error.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  input  logic        halt,
  fetch_ctrl_if.master mem,
  output logic [15:0] instr,
  output logic [15:0] PC2,
  output logic        valid,
  output logic        err,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [15:0] skid_data_q, skid_data_d;
  logic [15:0] skid_pc2_q, skid_pc2_d;

  logic        mem_rd;
  logic        accepted;
  logic        deliver;
  logic [15:0] pc_plus2;

  assign mem_rd   = (state_q == S_FETCH) && !rst;
  assign accepted = mem_rd && !mem.memStall;
  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc2_d       = pc2_q;
    // A live instruction retires whenever decode is not stalled.
    valid_d     = valid_q && stall;
    skid_data_d = skid_data_q;
    skid_pc2_d  = skid_pc2_q;
    deliver     = 1'b0;
    err_d       = err_q
                | ((state_q == S_FETCH) && mem.memDone && !accepted)
                | ((state_q == S_HOLD)  && mem.memDone);

    if (state_q == S_HALTED) begin
      state_d = S_HALTED;
    end else if (redirect) begin
      pc_d        = redirectPC;
      valid_d     = 1'b0;
      skid_data_d = 16'h0000;
      skid_pc2_d  = 16'h0000;
      // A read still in flight must be drained before the new stream starts.
      if (((state_q == S_WAIT) || (state_q == S_DRAIN) || accepted) && !mem.memDone)
        state_d = S_DRAIN;
      else
        state_d = S_FETCH;
    end else if (halt) begin
      state_d     = S_HALTED;
      valid_d     = 1'b0;
      skid_data_d = 16'h0000;
      skid_pc2_d  = 16'h0000;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accepted) begin
            if (mem.memDone) deliver = 1'b1;
            else             state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.memDone) deliver = 1'b1;
        end
        S_HOLD: begin
          if (!stall) begin
            instr_d = skid_data_q;
            pc2_d   = skid_pc2_q;
            valid_d = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (mem.memDone) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase

      if (deliver) begin
        pc_d = pc_plus2;
        if (!valid_q || !stall) begin
          instr_d = mem.memData;
          pc2_d   = pc_plus2;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end else begin
          skid_data_d = mem.memData;
          skid_pc2_d  = pc_plus2;
          state_d     = S_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= 16'h0000;
      pc2_q       <= 16'h0000;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      skid_data_q <= 16'h0000;
      skid_pc2_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc2_q       <= pc2_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      skid_data_q <= skid_data_d;
      skid_pc2_q  <= skid_pc2_d;
    end
  end

  assign mem.memAddr = pc_q;
  assign mem.memRd   = mem_rd;
  assign instr       = instr_q;
  assign PC2         = pc2_q;
  assign valid       = valid_q;
  assign err         = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic, all
// checked against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        halt;
  logic [15:0] instr;
  logic [15:0] PC2;
  logic        valid;
  logic        err;
  logic [2:0]  state_o;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .halt       (halt),
    .mem        (bus),
    .instr      (instr),
    .PC2        (PC2),
    .valid      (valid),
    .err        (err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: fetch pointer, output slot, parked words, read bookkeeping.
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pc2;
  logic        m_valid;
  logic        m_err;
  logic        m_busy;
  logic        m_drain;
  logic        m_halt;
  logic [31:0] skid_q[$];

  function automatic logic m_rd();
    return !m_halt && !m_busy && !m_drain && (skid_q.size() == 0);
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h5AC3) + 16'h0101;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("memAddr", bus.memAddr, m_pc);
    chk("memRd", {15'd0, bus.memRd}, {15'd0, (!rst && m_rd())});
    chk("valid", {15'd0, valid}, {15'd0, m_valid});
    chk("err", {15'd0, err}, {15'd0, m_err});
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("PC2", PC2, m_pc2);
    end
  endtask

  task automatic model_next();
    logic acc, done, got;
    if (rst) begin
      m_pc = RESET_PC; m_instr = 16'h0000; m_pc2 = 16'h0000;
      m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_drain = 1'b0; m_halt = 1'b0;
      skid_q.delete();
      return;
    end
    if (m_halt) return;
    acc  = m_rd() && !bus.memStall;
    done = bus.memDone;
    if (done && !(m_busy || m_drain || acc)) m_err = 1'b1;
    if (redirect) begin
      m_drain = (m_busy || m_drain || acc) && !done;
      m_busy  = 1'b0;
      m_pc    = redirectPC;
      m_valid = 1'b0;
      skid_q.delete();
      return;
    end
    if (halt) begin
      m_halt = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_drain = 1'b0;
      skid_q.delete();
      return;
    end
    got = done && (m_busy || acc);
    if (m_drain && done) m_drain = 1'b0;
    m_busy = (m_busy || acc) && !done;
    if (got) begin
      m_pc = m_pc + 16'd2;
      if (!m_valid || !stall) begin
        m_instr = bus.memData; m_pc2 = m_pc; m_valid = 1'b1;
      end else begin
        skid_q.push_back({m_pc, bus.memData});
      end
    end else if ((skid_q.size() != 0) && !stall) begin
      {m_pc2, m_instr} = skid_q.pop_front();
      m_valid = 1'b1;
    end else if (m_valid && !stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPC = 16'h0000; halt = 1'b0;
    bus.memStall = 1'b0; bus.memDone = 1'b0; bus.memData = 16'h0000;
  endtask

  initial begin
    logic [15:0] r;
    idle_inputs();
    m_pc = RESET_PC; m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0;
    m_err = 1'b0; m_busy = 1'b0; m_drain = 1'b0; m_halt = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    chk("rst_instr", instr, 16'h0000);
    chk("rst_PC2", PC2, 16'h0000);
    rst = 1'b0;

    // Zero-wait stream after reset
    for (int i = 0; i < 4; i++) begin
      chk("zw_addr", bus.memAddr, 16'(2 * i));
      bus.memDone = 1'b1;
      bus.memData = 16'hA000 + 16'(i);
      tick();
      chk("zw_instr", instr, 16'hA000 + 16'(i));
      chk("zw_PC2", PC2, 16'(2 * i + 2));
      chk("zw_valid", {15'd0, valid}, 16'd1);
    end

    // memStall for three cycles at 0x0010
    bus.memDone = 1'b0; bus.memStall = 1'b1; redirect = 1'b1; redirectPC = 16'h0010;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_addr", bus.memAddr, 16'h0010);
      chk("ms_rd", {15'd0, bus.memRd}, 16'd1);
    end
    bus.memStall = 1'b0; bus.memDone = 1'b1; bus.memData = 16'h1234;
    tick();
    chk("ms_instr", instr, 16'h1234);
    chk("ms_PC2", PC2, 16'h0012);

    // Decode stall while the next word returns: word parks, then appears
    stall = 1'b1; bus.memDone = 1'b1; bus.memData = 16'hB000;
    tick();
    chk("hold_instr", instr, 16'h1234);
    chk("hold_rd", {15'd0, bus.memRd}, 16'd0);
    bus.memDone = 1'b0;
    tick();
    chk("hold_instr2", instr, 16'h1234);
    stall = 1'b0;
    tick();
    chk("skid_instr", instr, 16'hB000);
    chk("skid_PC2", PC2, 16'h0014);
    bus.memDone = 1'b1; bus.memData = 16'hB001;
    tick();
    chk("after_skid", instr, 16'hB001);
    chk("after_skid_PC2", PC2, 16'h0016);

    // Redirect while waiting: drain the stale word
    bus.memDone = 1'b0;
    tick();
    redirect = 1'b1; redirectPC = 16'h0100;
    tick();
    chk("drain_valid", {15'd0, valid}, 16'd0);
    chk("drain_rd", {15'd0, bus.memRd}, 16'd0);
    redirect = 1'b0; bus.memDone = 1'b1; bus.memData = 16'hDEAD;
    tick();
    chk("drain_addr", bus.memAddr, 16'h0100);
    chk("drain_discard", {15'd0, valid}, 16'd0);
    bus.memData = 16'hC000;
    tick();
    chk("redir_instr", instr, 16'hC000);
    chk("redir_PC2", PC2, 16'h0102);

    // Halt with redirect: redirect wins; halt alone freezes until reset
    halt = 1'b1; redirect = 1'b1; redirectPC = 16'h0200; bus.memStall = 1'b1; bus.memDone = 1'b0;
    tick();
    chk("hr_addr", bus.memAddr, 16'h0200);
    chk("hr_rd", {15'd0, bus.memRd}, 16'd1);
    redirect = 1'b0; bus.memStall = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      redirect = 1'(i & 1); redirectPC = 16'h0300; bus.memDone = 1'(i & 1); stall = 1'(i >> 1);
      tick();
      chk("halt_rd", {15'd0, bus.memRd}, 16'd0);
      chk("halt_valid", {15'd0, valid}, 16'd0);
      chk("halt_addr", bus.memAddr, 16'h0200);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("halt_rst_addr", bus.memAddr, RESET_PC);
    rst = 1'b0;

    // PC wrap and spurious memDone in HOLD
    redirect = 1'b1; redirectPC = 16'hFFFE; bus.memStall = 1'b1;
    tick();
    redirect = 1'b0; bus.memStall = 1'b0; bus.memDone = 1'b1; bus.memData = 16'hE000;
    tick();
    chk("wrap_PC2", PC2, 16'h0000);
    chk("wrap_addr", bus.memAddr, 16'h0000);
    stall = 1'b1; bus.memData = 16'hE001;
    tick();
    tick();
    chk("spur_err", {15'd0, err}, 16'd1);
    stall = 1'b0; bus.memDone = 1'b0;
    tick();
    chk("spur_err_sticky", {15'd0, err}, 16'd1);
    chk("spur_skid", instr, 16'hE001);
    rst = 1'b1;
    tick();
    chk("err_cleared", {15'd0, err}, 16'd0);
    rst = 1'b0;

    // Randomized protocol-clean traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = (m_halt && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 499) == 0);
      stall      = ($urandom_range(0, 2) == 0);
      redirect   = ($urandom_range(0, 24) == 0);
      r          = 16'($urandom);
      redirectPC = r & 16'hFFFE;
      halt       = ($urandom_range(0, 149) == 0);
      bus.memStall = ($urandom_range(0, 3) == 0);
      if (m_busy || m_drain)                bus.memDone = ($urandom_range(0, 2) == 0);
      else if (m_rd() && !bus.memStall)     bus.memDone = 1'($urandom_range(0, 1));
      else                                  bus.memDone = 1'b0;
      bus.memData = mem_word(m_pc);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 stall  in  1  decode cannot accept a new instruction this cycle.
REQ-005 redirect  in  1  branch/jump resolved; flush and refetch from redirectPC.
REQ-006 redirectPC  in  16  target PC for redirect.
REQ-007 halt  in  1  HALT decoded; stop fetching.
REQ-008 memStall  in  1  instruction memory busy; request this cycle not accepted.
REQ-009 memDone  in  1  memData valid this cycle.
REQ-010 memData  in  16  instruction word from memory.
REQ-011 memAddr  out  16  fetch address; always equals PC register.
REQ-012 memRd  out  1  read request.
REQ-013 instr  out  16  IF/ID instruction register.
REQ-014 PC2  out  16  address of instr plus 2.
REQ-015 valid  out  1  instr/PC2 hold a live instruction.
REQ-016 err  out  1  sticky memory protocol error flag.

Function
REQ-017 States: FETCH, WAIT, HOLD, DRAIN, HALTED (2-3 bit encoding, no other reachable states).
REQ-018 memRd = 1 only in FETCH and not during rst; 0 in all other states.
REQ-019 Request accepted when memRd && !memStall; on memStall stay FETCH, PC unchanged, re-request next cycle.
REQ-020 FETCH, accepted, memDone same cycle: deliver (REQ-022); accepted without memDone: go WAIT.
REQ-021 WAIT: memDone -> deliver; else remain WAIT.
REQ-022 Deliver: PC <= PC+2; if !valid || !stall then instr <= memData, PC2 <= PC+2, valid <= 1, go FETCH; else skid <= memData/PC+2, go HOLD.
REQ-023 HOLD: memRd=0; when !stall move skid into instr/PC2, valid stays 1, go FETCH.
REQ-024 Output register: when valid && !stall and no new instruction loaded, valid <= 0 next cycle; when stall, instr/PC2/valid hold.
REQ-025 Redirect (highest priority, any state except HALTED): PC <= redirectPC, valid <= 0, skid discarded; from WAIT, or FETCH with accepted request and no memDone, go DRAIN; otherwise go FETCH; same-cycle memDone data discarded.
REQ-026 DRAIN: memRd=0; on memDone discard data, go FETCH; redirect in DRAIN updates PC, stays DRAIN.
REQ-027 Halt (when !redirect): go HALTED next cycle, valid <= 0, PC frozen, any outstanding or same-cycle data discarded; redirect beats halt in the same cycle.
REQ-028 HALTED: absorbing until rst; redirect, stall, halt ignored; memDone ignored.
REQ-029 err <= 1 on memDone in FETCH without an accepted request, or in HOLD; cleared only by rst.
REQ-030 PC and PC2 arithmetic modulo 2^16: 16'hFFFE + 2 = 16'h0000, no error.
REQ-031 Latency: zero-wait memory (memDone with request) -> valid one cycle after memRd; steady-state throughput one instruction/cycle with stall low.

Reset
REQ-032 rst high at a clock edge: state FETCH, PC = RESET_PC, instr = 0, PC2 = 0, valid = 0, err = 0, skid cleared; overrides all other inputs including mid-WAIT/DRAIN/HALTED.
REQ-033 memDone arriving in the first cycle after reset is treated per REQ-029.

Verification
REQ-034 Reset, zero-wait memory returning 16'hA000,16'hA001,...: memAddr 0,2,4; instr valid each cycle from cycle 2; PC2 = 2,4,6.
REQ-035 memStall high 3 cycles at PC 16'h0010 then memDone: memAddr holds 16'h0010, memRd high throughout, instr loads on done, PC2 = 16'h0012.
REQ-036 stall high 2 cycles while next fetch completes: FSM enters HOLD, instr unchanged; stall low -> skid word appears next cycle, no loss/duplication.
REQ-037 redirect to 16'h0100 while WAIT: valid drops, DRAIN discards returning word, next memAddr 16'h0100, fetched PC2 = 16'h0102.
REQ-038 halt and redirect same cycle -> redirect taken; halt alone -> memRd 0, valid 0 forever, PC frozen until rst returns PC to RESET_PC.
REQ-039 PC 16'hFFFE fetch -> PC2 16'h0000, next memAddr 16'h0000; spurious memDone in HOLD -> err = 1 until rst.
